// File: rtl/mac_seq_pkg.sv
// Shared types and sizing for the MAC operand sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 16;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mac_seq_operand_buf.sv
// DEPTH x WIDTH operand register file: one synchronous write port, one combinational read port.
module mac_seq_operand_buf
  import mac_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Streams one kernel window of activation/weight pairs into the MAC.
// Optional zero-pair skipping is enabled by defining MAC_SEQ_ZERO_SKIP_EN.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     mac_busy,
  output logic [WIDTH-1:0]         x,
  output logic [WIDTH-1:0]         y,
  output logic                     mac_valid,
  output logic                     acc_clr,
  output logic                     seq_busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(DEPTH);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   len_q;
  logic [WIDTH-1:0] act_rd, wgt_rd;
  logic             len_ok, last, skip;

  mac_seq_operand_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_act_buf (
    .clock (clock),
    .we    (wr_en && !wr_sel && (state_q == IDLE)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (act_rd)
  );

  mac_seq_operand_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_wgt_buf (
    .clock (clock),
    .we    (wr_en && wr_sel && (state_q == IDLE)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (wgt_rd)
  );

  assign len_ok = (len != '0) && (len <= LEN_MAX);
  // Compare against len-1 so a full-depth window never needs idx to wrap.
  assign last   = ({1'b0, idx_q} == (len_q - (IDX_W + 1)'(1)));

`ifdef MAC_SEQ_ZERO_SKIP_EN
  assign skip = (act_rd == '0) || (wgt_rd == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      x         <= '0;
      y         <= '0;
      mac_valid <= 1'b0;
      acc_clr   <= 1'b0;
      seq_busy  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mac_valid <= 1'b0;
      acc_clr   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q    <= len;
              idx_q    <= '0;
              seq_busy <= 1'b1;
              state_q  <= CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          acc_clr <= 1'b1;
          state_q <= STREAM;
        end
        STREAM: begin
          // Skipped pairs advance regardless of mac_busy; x/y keep the last issued pair.
          if (skip || !mac_busy) begin
            if (!skip) begin
              x         <= act_rd;
              y         <= wgt_rd;
              mac_valid <= 1'b1;
            end
            if (last) state_q <= DRAIN;
            else      idx_q   <= idx_q + IDX_W'(1);
          end
        end
        DRAIN: state_q <= DONE;
        DONE: begin
          done     <= 1'b1;
          seq_busy <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed self-checking bench for mac_operand_sequencer (WIDTH=16, DEPTH=16).
module tb_mac_operand_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic             wr_sel = 1'b0;
  logic [3:0]       wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic [4:0]       len = '0;
  logic             mac_busy = 1'b0;
  logic [WIDTH-1:0] x, y;
  logic             mac_valid, acc_clr, seq_busy, done, err;

  int checks = 0;
  int errors = 0;
  int sum;
  int cnt;

  mac_operand_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .len       (len),
    .mac_busy  (mac_busy),
    .x         (x),
    .y         (y),
    .mac_valid (mac_valid),
    .acc_clr   (acc_clr),
    .seq_busy  (seq_busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [WIDTH-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [4:0] n);
    start = 1'b1; len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_valid"}, mac_valid, 0);
    check({tag, "_clr"}, acc_clr, 0);
    check({tag, "_busy"}, seq_busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();

    // Window 1: act=1..4, wgt=2, no stalls
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 4'(i), 16'(i + 1));
      wr(1'b1, 4'(i), 16'd2);
    end
    launch(5'd4);
    check("w1_busy_e0", seq_busy, 1);
    check("w1_clr_e0", acc_clr, 0);
    tick();
    check("w1_clr_e1", acc_clr, 1);
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("w1_valid", mac_valid, 1);
      check("w1_x", x, k + 1);
      check("w1_y", y, 2);
      check("w1_clr_off", acc_clr, 0);
      if (mac_valid) sum += int'(x) * int'(y);
    end
    tick();
    check("w1_drain_valid", mac_valid, 0);
    check("w1_drain_done", done, 0);
    tick();
    check("w1_done", done, 1);
    check("w1_idle", seq_busy, 0);
    check("w1_sum", sum, 20);
    tick();
    check("w1_done_pulse", done, 0);

    // Window 2: stall 3 cycles after pair 1 issued
    launch(5'd4);
    tick();
    tick();
    check("w2_x0", x, 1);
    tick();
    check("w2_x1", x, 2);
    mac_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("w2_stall_valid", mac_valid, 0);
      check("w2_stall_x", x, 2);
    end
    mac_busy = 1'b0;
    tick();
    check("w2_x2", x, 3);
    check("w2_v2", mac_valid, 1);
    tick();
    check("w2_x3", x, 4);
    tick();
    check("w2_no_done_e9", done, 0);
    tick();
    check("w2_done_e10", done, 1);
    tick();

    // Illegal lengths
    launch(5'd0);
    check("len0_err", err, 1);
    check("len0_busy", seq_busy, 0);
    check("len0_clr", acc_clr, 0);
    tick();
    check("len0_err_pulse", err, 0);
    check("len0_clr2", acc_clr, 0);
    launch(5'd17);
    check("len17_err", err, 1);
    check("len17_busy", seq_busy, 0);
    tick();
    check("len17_err_pulse", err, 0);
    check("len17_clr", acc_clr, 0);
    check("len17_busy2", seq_busy, 0);

    // Reset mid-stream at index 2
    launch(5'd4);
    tick(); tick(); tick(); tick();
    check("abort_x2", x, 3);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    tick(); tick();
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    launch(5'd2);
    tick();
    tick();
    check("rerun_x0", x, 1);
    check("rerun_v0", mac_valid, 1);
    tick();
    check("rerun_x1", x, 2);
    tick();
    check("rerun_drain", done, 0);
    tick();
    check("rerun_done", done, 1);
    tick();

    // Full window, len=DEPTH
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 4'(i), 16'(i + 10));
      wr(1'b1, 4'(i), 16'(i + 1));
    end
    launch(5'd16);
    tick();
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("full_x", x, k + 10);
      check("full_y", y, k + 1);
      if (mac_valid) cnt++;
    end
    check("full_issues", cnt, 16);
    tick();
    check("full_drain_valid", mac_valid, 0);
    check("full_no_done_e18", done, 0);
    tick();
    check("full_done_e19", done, 1);
    tick();

`ifdef MAC_SEQ_ZERO_SKIP_EN
    wr(1'b0, 4'd0, 16'd3);
    wr(1'b0, 4'd1, 16'd0);
    wr(1'b0, 4'd2, 16'd5);
    wr(1'b0, 4'd3, 16'd0);
    for (int i = 0; i < 4; i++) wr(1'b1, 4'(i), 16'd1);
    launch(5'd4);
    tick();
    tick();
    check("zs_v0", mac_valid, 1);
    check("zs_x0", x, 3);
    tick();
    check("zs_v1", mac_valid, 0);
    tick();
    check("zs_v2", mac_valid, 1);
    check("zs_x2", x, 5);
    tick();
    check("zs_v3", mac_valid, 0);
    tick();
    check("zs_no_done", done, 0);
    tick();
    check("zs_done", done, 1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
